// File: rtl/panda_axis_icb_writer_if.sv
// Bundles the AXIS slave-side and ICB master-side signals of the
// stream-to-memory writer. One instance carries both buses; each side of
// the connection picks the modport matching its role.
interface panda_axis_icb_writer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  localparam int KEEP_WIDTH = DATA_WIDTH / 8;

  // AXIS stream
  logic [DATA_WIDTH-1:0] s_axis_data;
  logic [KEEP_WIDTH-1:0] s_axis_keep;
  logic                  s_axis_last;
  logic                  s_axis_valid;
  logic                  s_axis_ready;

  // ICB command / response
  logic [ADDR_WIDTH-1:0] m_icb_cmd_addr;
  logic                  m_icb_cmd_read;
  logic [DATA_WIDTH-1:0] m_icb_cmd_wdata;
  logic [KEEP_WIDTH-1:0] m_icb_cmd_wmask;
  logic                  m_icb_cmd_valid;
  logic                  m_icb_cmd_ready;
  logic [DATA_WIDTH-1:0] m_icb_rsp_rdata;
  logic                  m_icb_rsp_err;
  logic                  m_icb_rsp_valid;
  logic                  m_icb_rsp_ready;

  // Stream consumer (the writer)
  modport axis_slave (
    input  s_axis_data, s_axis_keep, s_axis_last, s_axis_valid,
    output s_axis_ready
  );

  // Stream producer
  modport axis_master (
    output s_axis_data, s_axis_keep, s_axis_last, s_axis_valid,
    input  s_axis_ready
  );

  // Bus initiator (the writer)
  modport icb_master (
    output m_icb_cmd_addr, m_icb_cmd_read, m_icb_cmd_wdata, m_icb_cmd_wmask,
           m_icb_cmd_valid, m_icb_rsp_ready,
    input  m_icb_cmd_ready, m_icb_rsp_rdata, m_icb_rsp_err, m_icb_rsp_valid
  );

  // Memory / interconnect target
  modport icb_slave (
    input  m_icb_cmd_addr, m_icb_cmd_read, m_icb_cmd_wdata, m_icb_cmd_wmask,
           m_icb_cmd_valid, m_icb_rsp_ready,
    output m_icb_cmd_ready, m_icb_rsp_rdata, m_icb_rsp_err, m_icb_rsp_valid
  );
endinterface

// File: rtl/panda_axis_icb_writer.sv
// Stream-to-memory write stage: every accepted AXIS beat becomes one ICB
// write to the next word address after a programmed base. In-flight writes
// are bounded by OST_MAX; responses are collected for done/err reporting.
module panda_axis_icb_writer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int OST_MAX    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [15:0]           beat_cnt,
  panda_axis_icb_writer_if.axis_slave s_axis,
  panda_axis_icb_writer_if.icb_master m_icb
);
  localparam int KEEP_WIDTH = DATA_WIDTH / 8;
  localparam int CNT_W      = 4;  // holds OST_MAX up to 15
  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(KEEP_WIDTH);
  localparam logic [CNT_W-1:0]      OST_LIM   = CNT_W'(OST_MAX);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  cmd_valid_q, cmd_valid_d;
  logic [ADDR_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
  logic [DATA_WIDTH-1:0] cmd_wdata_q, cmd_wdata_d;
  logic [KEEP_WIDTH-1:0] cmd_wmask_q, cmd_wmask_d;
  logic [CNT_W-1:0]      inflight_q, inflight_d;
  logic [15:0]           beat_cnt_q, beat_cnt_d;
  logic                  err_q, err_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic axis_ready, rsp_ready;
  logic axis_hs, cmd_hs, rsp_hs;

  // Read data is meaningless for a write-only stage.
  logic unused_rdata;
  assign unused_rdata = ^m_icb.m_icb_rsp_rdata;

  // Ready terms: a beat may enter only when the command slot frees this
  // cycle and the outstanding budget has room.
  assign axis_ready = (state_q == S_RUN) && (!cmd_valid_q || m_icb.m_icb_cmd_ready)
                      && (inflight_q < OST_LIM);
  assign rsp_ready  = (state_q != S_IDLE);
  assign axis_hs    = s_axis.s_axis_valid && axis_ready;
  assign cmd_hs     = cmd_valid_q && m_icb.m_icb_cmd_ready;
  assign rsp_hs     = m_icb.m_icb_rsp_valid && rsp_ready;

  // Next-state computation for the FSM and the command/accounting datapath.
  always_comb begin
    // NOTE: every _d gets a default first, so no path can leave one unassigned and infer a latch.
    state_d     = state_q;
    addr_d      = addr_q;
    cmd_valid_d = cmd_valid_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    cmd_wmask_d = cmd_wmask_q;
    inflight_d  = inflight_q;
    beat_cnt_d  = beat_cnt_q;
    err_d       = err_q;

    if (axis_hs) begin
      cmd_valid_d = 1'b1;
      cmd_addr_d  = addr_q;
      cmd_wdata_d = s_axis.s_axis_data;
      cmd_wmask_d = s_axis.s_axis_keep;
      addr_d      = addr_q + ADDR_STEP;
      beat_cnt_d  = beat_cnt_q + 16'd1;
    end else if (cmd_hs) begin
      cmd_valid_d = 1'b0;
    end

    unique case ({axis_hs, rsp_hs})
      2'b10:   inflight_d = inflight_q + CNT_W'(1);
      2'b01:   inflight_d = inflight_q - CNT_W'(1);
      default: inflight_d = inflight_q;
    endcase

    if (rsp_hs) err_d = err_q | m_icb.m_icb_rsp_err;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_RUN;
          addr_d     = base_addr;
          err_d      = 1'b0;
          beat_cnt_d = 16'd0;
        end
      end
      S_RUN: begin
        if (axis_hs && s_axis.s_axis_last) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (!cmd_valid_d && (inflight_d == '0)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_q == S_DRAIN) && (state_d == S_IDLE);
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the command payload registers are reset too, so the bus shows zeros rather than stale data after reset.
      state_q     <= S_IDLE;
      addr_q      <= '0;
      cmd_valid_q <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      cmd_wmask_q <= '0;
      inflight_q  <= '0;
      beat_cnt_q  <= 16'd0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
      state_q     <= state_d;
      addr_q      <= addr_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      cmd_wmask_q <= cmd_wmask_d;
      inflight_q  <= inflight_d;
      beat_cnt_q  <= beat_cnt_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign busy                  = busy_q;
  assign done                  = done_q;
  assign err                   = err_q;
  assign beat_cnt              = beat_cnt_q;
  assign s_axis.s_axis_ready   = axis_ready;
  assign m_icb.m_icb_cmd_addr  = cmd_addr_q;
  assign m_icb.m_icb_cmd_read  = 1'b0;
  assign m_icb.m_icb_cmd_wdata = cmd_wdata_q;
  assign m_icb.m_icb_cmd_wmask = cmd_wmask_q;
  assign m_icb.m_icb_cmd_valid = cmd_valid_q;
  assign m_icb.m_icb_rsp_ready = rsp_ready;
endmodule

// File: tb/tb_panda_axis_icb_writer.sv
// Bench for panda_axis_icb_writer: directed transfers with a scoreboard of
// expected ICB commands, an ICB target model with configurable response
// latency/hold/error, and status checks at each completion.
`timescale 1ns/1ps
module tb_panda_axis_icb_writer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] base_addr;
  logic        busy, done, err;
  logic [15:0] beat_cnt;

  panda_axis_icb_writer_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

  panda_axis_icb_writer #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .OST_MAX(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .beat_cnt  (beat_cnt),
    .s_axis    (bus),
    .m_icb     (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Scoreboard: {addr, wdata, wmask} in expected issue order.
  logic [67:0] exp_q[$];

  // Target model controls (written by the main sequence).
  int cmd_mode = 0;   // 0: ready=1, 1: random, 2: ready=0
  int rsp_lat  = 0;
  bit rsp_hold = 0;
  bit flush    = 0;
  int err_at   = -1;  // global response index that returns rsp_err=1
  int cmd_total = 0;
  int rsp_total = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ICB target + command monitor: samples at negedge, drives after posedge.
  initial begin : icb_target
    int  cyc = 0;
    int  pending[$];
    bit  cmd_fire, rsp_fire, stall_prev;
    logic [68:0] stall_snap;
    logic [67:0] exp;
    stall_prev = 0;
    stall_snap = '0;
    bus.m_icb_cmd_ready = 1'b0;
    bus.m_icb_rsp_valid = 1'b0;
    bus.m_icb_rsp_err   = 1'b0;
    bus.m_icb_rsp_rdata = '0;
    forever begin
      @(negedge clk);
      cmd_fire = bus.m_icb_cmd_valid && bus.m_icb_cmd_ready;
      rsp_fire = bus.m_icb_rsp_valid && bus.m_icb_rsp_ready;
      if (rst_n && stall_prev)
        check("cmd_stable_while_stalled",
              {bus.m_icb_cmd_valid, bus.m_icb_cmd_addr, bus.m_icb_cmd_wdata, bus.m_icb_cmd_wmask},
              stall_snap);
      stall_prev = rst_n && bus.m_icb_cmd_valid && !bus.m_icb_cmd_ready;
      stall_snap = {bus.m_icb_cmd_valid, bus.m_icb_cmd_addr, bus.m_icb_cmd_wdata, bus.m_icb_cmd_wmask};
      if (cmd_fire) begin
        cmd_total++;
        check("cmd_expected", (exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          exp = exp_q.pop_front();
          check("cmd_addr_data_mask",
                {bus.m_icb_cmd_addr, bus.m_icb_cmd_wdata, bus.m_icb_cmd_wmask}, exp);
          check("cmd_read_low", bus.m_icb_cmd_read, 0);
        end
      end
      @(posedge clk); #1;
      cyc++;
      if (flush) begin
        pending.delete();
        flush = 0;
        rsp_fire = 0;
        cmd_fire = 0;
      end
      if (rsp_fire) begin
        void'(pending.pop_front());
        rsp_total++;
      end
      if (cmd_fire) pending.push_back(cyc + rsp_lat);
      if (!rsp_hold && pending.size() != 0 && pending[0] <= cyc) begin
        bus.m_icb_rsp_valid = 1'b1;
        bus.m_icb_rsp_err   = (rsp_total == err_at);
      end else begin
        bus.m_icb_rsp_valid = 1'b0;
        bus.m_icb_rsp_err   = 1'b0;
      end
      case (cmd_mode)
        0:       bus.m_icb_cmd_ready = 1'b1;
        1:       bus.m_icb_cmd_ready = 1'($urandom_range(0, 1));
        default: bus.m_icb_cmd_ready = 1'b0;
      endcase
    end
  end

  task automatic do_start(input logic [31:0] base);
    start = 1'b1;
    base_addr = base;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Presents one beat, records its expected command, waits for acceptance.
  task automatic drive_beat(input logic [31:0] a, input logic [31:0] d, input logic [3:0] k,
                            input logic l, input bit gaps, output int waits);
    if (gaps) repeat ($urandom_range(0, 2)) begin
      bus.s_axis_valid = 1'b0;
      @(posedge clk); #1;
    end
    bus.s_axis_valid = 1'b1;
    bus.s_axis_data  = d;
    bus.s_axis_keep  = k;
    bus.s_axis_last  = l;
    exp_q.push_back({a, d, k});
    waits = 0;
    do begin @(negedge clk); waits++; end while (!bus.s_axis_ready && waits < 300);
    if (!bus.s_axis_ready) check("beat_accept_timeout", 0, 1);
    @(posedge clk); #1;
    bus.s_axis_valid = 1'b0;
    bus.s_axis_last  = 1'b0;
  endtask

  task automatic wait_done(input string name, input logic [15:0] exp_cnt, input logic exp_err);
    int n = 0;
    do begin @(negedge clk); n++; end while (!done && n < 300);
    check({name, "_done_seen"}, done, 1);
    check({name, "_busy_low_at_done"}, busy, 0);
    check({name, "_beat_cnt"}, beat_cnt, exp_cnt);
    check({name, "_err"}, err, exp_err);
    check({name, "_all_cmds_issued"}, exp_q.size(), 0);
    @(negedge clk);
    check({name, "_done_single_pulse"}, done, 0);
    @(posedge clk); #1;
  endtask

  function automatic logic [127:0] reset_view();
    return {busy, done, err, beat_cnt, bus.m_icb_cmd_valid, bus.m_icb_rsp_ready,
            bus.s_axis_ready, bus.m_icb_cmd_read, bus.m_icb_cmd_addr,
            bus.m_icb_cmd_wdata, bus.m_icb_cmd_wmask};
  endfunction

  initial begin : main
    int w, wsum, n;
    int c0, r0;
    logic [31:0] a, d;
    logic [3:0]  k;

    rst_n = 1'b0;
    start = 1'b0;
    base_addr = '0;
    bus.s_axis_valid = 1'b0;
    bus.s_axis_data  = '0;
    bus.s_axis_keep  = '0;
    bus.s_axis_last  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("reset_outputs", reset_view(), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Single beat, response two cycles after the command.
    cmd_mode = 0; rsp_lat = 2;
    do_start(32'h0000_1000);
    @(negedge clk);
    check("single_busy_after_start", busy, 1);
    check("single_ready_after_start", bus.s_axis_ready, 1);
    @(posedge clk); #1;
    drive_beat(32'h0000_1000, 32'hA5A5_A5A5, 4'hF, 1'b1, 0, w);
    @(negedge clk);
    check("single_cmd_next_cycle", bus.m_icb_cmd_valid, 1);
    @(posedge clk); #1;
    wait_done("single", 16'd1, 1'b0);

    // 8-beat burst at full rate.
    rsp_lat = 0; wsum = 0;
    do_start(32'h0000_2000);
    for (int i = 0; i < 8; i++) begin
      a = 32'h0000_2000 + 32'(4 * i);
      drive_beat(a, 32'h1111_0000 + 32'(i), 4'hF, (i == 7), 0, w);
      wsum += w;
    end
    check("burst_no_bubbles", wsum, 8);
    wait_done("burst", 16'd8, 1'b0);

    // Outstanding limit: hold responses, four commands fit, the fifth waits.
    rsp_hold = 1; c0 = cmd_total;
    do_start(32'h0000_3000);
    for (int i = 0; i < 4; i++)
      drive_beat(32'h0000_3000 + 32'(4 * i), 32'h3333_0000 + 32'(i), 4'h3, 1'b0, 0, w);
    bus.s_axis_valid = 1'b1;
    bus.s_axis_data  = 32'h3333_0004;
    bus.s_axis_keep  = 4'h3;
    bus.s_axis_last  = 1'b0;
    exp_q.push_back({32'h0000_3010, 32'h3333_0004, 4'h3});
    n = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.s_axis_ready) n++;
    end
    check("ost_ready_held_low", n, 0);
    @(posedge clk); #1;
    check("ost_cmds_issued", cmd_total - c0, 4);
    r0 = rsp_total;
    rsp_hold = 0;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.s_axis_ready && n < 50);
    check("ost_ready_after_rsp", bus.s_axis_ready, 1);
    check("ost_slot_freed_by_rsp", (rsp_total > r0), 1);
    @(posedge clk); #1;
    bus.s_axis_valid = 1'b0;
    drive_beat(32'h0000_3014, 32'h3333_0005, 4'h3, 1'b1, 0, w);
    wait_done("ost", 16'd6, 1'b0);

    // Error on the 3rd of 5 responses; a start during RUN is ignored.
    rsp_lat = 1;
    err_at = rsp_total + 2;
    do_start(32'h0000_8000);
    for (int i = 0; i < 5; i++) begin
      drive_beat(32'h0000_8000 + 32'(4 * i), 32'h8888_0000 + 32'(i), 4'hC, (i == 4), 0, w);
      if (i == 1) begin
        do_start(32'h0000_9000);
        @(negedge clk);
        check("start_ignored_beat_cnt", beat_cnt, 2);
        check("start_ignored_busy", busy, 1);
        @(posedge clk); #1;
      end
    end
    wait_done("err", 16'd5, 1'b1);
    err_at = -1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("err_sticky_after_done", err, 1);
    @(posedge clk); #1;

    // Random valid gaps and cmd_ready back-pressure over 64 beats.
    cmd_mode = 1;
    do_start(32'h4000_0000);
    @(negedge clk);
    check("err_cleared_by_start", err, 0);
    check("beat_cnt_cleared_by_start", beat_cnt, 0);
    @(posedge clk); #1;
    for (int i = 0; i < 64; i++) begin
      d = $urandom;
      k = 4'($urandom_range(0, 15));
      if (i == 5) k = 4'h0;
      drive_beat(32'h4000_0000 + 32'(4 * i), d, k, (i == 63), 1, w);
    end
    wait_done("bp", 16'd64, 1'b0);

    // Reset in the middle of a transfer with a command pending.
    cmd_mode = 2; rsp_hold = 1;
    do_start(32'h0000_5000);
    drive_beat(32'h0000_5000, 32'h5555_5555, 4'hF, 1'b0, 0, w);
    bus.s_axis_valid = 1'b1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("midreset_outputs", reset_view(), 0);
    @(posedge clk); #1;
    bus.s_axis_valid = 1'b0;
    exp_q.delete();
    flush = 1;
    rsp_hold = 0;
    cmd_mode = 0;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Address wrap across the top of the address space.
    rsp_lat = 0;
    do_start(32'hFFFF_FFFC);
    drive_beat(32'hFFFF_FFFC, 32'hDEAD_BEEF, 4'hF, 1'b0, 0, w);
    drive_beat(32'h0000_0000, 32'hCAFE_F00D, 4'h5, 1'b1, 0, w);
    wait_done("wrap", 16'd2, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/panda_axis_icb_writer.md
# panda_axis_icb_writer

Stream-to-memory write stage: accepts beats on an AXIS slave port and issues one ICB write command per beat to consecutive word addresses starting at a programmed base. It sits directly downstream of an AXIS producer and upstream of an ICB memory or interconnect slave. It is the DUT-side counterpart of the `panda_axis_if` and `panda_icb_if` agents. It bounds in-flight writes, collects write responses, and reports completion and error status per transfer.

## Interface
Parameters:
- `DATA_WIDTH`, 32: AXIS data width and ICB data width; must be a multiple of 8 and ≤ 1024.
- `ADDR_WIDTH`, 32: ICB address width.
- `OST_MAX`, 4: maximum number of beats in flight (accepted but not yet responded), range 1–15.

Ports:
- `clk` in 1: the only clock; all logic is sampled on its rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `start` in 1: single-cycle transfer start; ignored unless the block is idle.
- `base_addr` in ADDR_WIDTH: first write address, sampled when `start` is accepted.
- `busy` out 1: high from `start` acceptance until `done`.
- `done` out 1: single-cycle pulse marking transfer completion.
- `err` out 1: sticky; set if any write response of the current transfer had `rsp_err` = 1.
- `beat_cnt` out 16: number of beats accepted in the current or most recent transfer.
- `s_axis_data` in DATA_WIDTH: write data.
- `s_axis_keep` in DATA_WIDTH/8: byte enables; used as the write mask.
- `s_axis_last` in 1: marks the final beat of the transfer.
- `s_axis_valid` in 1: AXIS valid.
- `s_axis_ready` out 1: AXIS ready.
- `m_icb_cmd_addr` out ADDR_WIDTH: command address.
- `m_icb_cmd_read` out 1: tied to 0.
- `m_icb_cmd_wdata` out DATA_WIDTH: command write data.
- `m_icb_cmd_wmask` out DATA_WIDTH/8: command write mask.
- `m_icb_cmd_valid` out 1: command valid.
- `m_icb_cmd_ready` in 1: command ready.
- `m_icb_rsp_rdata` in DATA_WIDTH: ignored.
- `m_icb_rsp_err` in 1: response error flag.
- `m_icb_rsp_valid` in 1: response valid.
- `m_icb_rsp_ready` out 1: response ready.

## Operation
- **States:** IDLE, RUN, DRAIN.
- **IDLE → RUN:** on `start`.
  - Latch `base_addr` into the address counter.
  - Clear `err` and `beat_cnt`.
- **RUN → DRAIN:** on the handshake of a beat with `s_axis_last` = 1.
- **DRAIN → IDLE:** when the command register is empty and `inflight` = 0.
  - This happens either on the edge of the final response handshake or, if already satisfied, on the next edge.
  - `done` pulses in the cycle after the transition.
- **Command register:** one entry holding addr, wdata and wmask, with valid = `m_icb_cmd_valid`.
- **AXIS ready:** `s_axis_ready` = (state == RUN) && (!cmd_valid || cmd_ready) && (inflight < OST_MAX).
  - This is a combinational path from `m_icb_cmd_ready`; the path is accepted.
- **On an AXIS handshake:**
  - Load the command register with the current address, `s_axis_data` and `s_axis_keep`.
  - Advance the address by DATA_WIDTH/8, wrapping modulo 2^ADDR_WIDTH.
  - Increment `beat_cnt` (16-bit, wraps).
  - Increment `inflight`.
- **On a command handshake with no new beat:** clear cmd_valid.
- **On a response handshake:** decrement `inflight`, and OR `m_icb_rsp_err` into `err`.
- **Simultaneous beat and response handshake:** `inflight` is unchanged.
- **Response ready:** `m_icb_rsp_ready` = (state != IDLE).
  - A response arriving in IDLE is not accepted and does not affect state.
- **Keep handling:** a beat with `s_axis_keep` = 0 is still issued as a command (mask 0).
- **`start` while busy:** ignored; no state change.

## Timing
- **Reset values:** state IDLE; `busy`, `done`, `err`, `m_icb_cmd_valid`, `m_icb_rsp_ready`, `s_axis_ready`, `m_icb_cmd_read` = 0; `beat_cnt` = 0; command address, wdata and wmask = 0.
- **Reset mid-transfer:** returns to IDLE in the next cycle and drops the pending command and `inflight`.
- **Start latency:** `start` at edge N makes `busy` = 1 and `s_axis_ready` eligible from cycle N+1.
- **Beat latency:** a beat accepted at edge N is presented on the ICB command bus in cycle N+1.
- **Throughput:** with `cmd_ready` held at 1 and responses returning within OST_MAX cycles, one beat per cycle.
- **Back-pressure:** `m_icb_cmd_valid`, addr, wdata and wmask hold stable until the command handshake.
- **Completion:** `busy` falls in the same cycle that `done` is high.

## Test plan
- **Single beat:** `base_addr` = 0x1000, one beat with data 0xA5A5A5A5, keep 0xF and last = 1, `cmd_ready` = 1, response after 2 cycles → one write to 0x1000 with mask 0xF; `done` pulses once; `beat_cnt` = 1; `err` = 0.
- **Burst:** 8-beat burst from 0x2000 with `cmd_ready` = 1 and zero-latency responses → addresses 0x2000–0x201C in steps of 4 with no bubbles; `beat_cnt` = 8.
- **Outstanding limit:** `rsp_valid` withheld, OST_MAX = 4 → exactly 4 commands issued, then `s_axis_ready` stays 0 until a response handshake frees one slot.
- **Error and start-while-busy:** 3rd of 5 responses has `rsp_err` = 1 → `err` = 1 at `done` and stays set until the next accepted `start`; a `start` pulse during RUN is ignored.
- **Back-pressure and reset:** random `cmd_ready`/`s_axis_valid` toggling over 64 beats → data, mask and address order match the input, and `m_icb_cmd` is stable while stalled; assert `rst_n` = 0 mid-transfer → all outputs reach reset values on the next cycle.
- **Address wrap:** `base_addr` = 0xFFFF_FFFC with a 2-beat transfer → addresses 0xFFFF_FFFC then 0x0000_0000.
